// File: rtl/cache_ctrl_wb.sv
// cache_ctrl_wb: miss controller for split I/D caches sharing one memory port.
// Data side is write-back: dirty victims are evicted before the refill.
module cache_ctrl_wb #(
    parameter int WORD_W = 16,
    parameter int WPL    = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16,
    parameter int PRIO_D = 1,
    localparam int LINE_W = WORD_W * WPL,
    localparam int OFF_W  = $clog2(WPL),
    localparam int LA_W   = ADDR_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_hit,
    input  logic [LINE_W-1:0] i_line,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [WORD_W-1:0] d_wdata,
    input  logic              d_hit,
    input  logic              d_dirty,
    input  logic [LINE_W-1:0] d_line,
    input  logic [LA_W-1:0]   d_victim_la,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic [WORD_W-1:0] instr,
    output logic              i_rdy,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_rdy,
    output logic              icache_we,
    output logic              dcache_we,
    output logic              dcache_wdirty,
    output logic [LINE_W-1:0] dcache_wline,
    output logic              mem_re,
    output logic              mem_we,
    output logic [LA_W-1:0]   mem_la,
    output logic [LINE_W-1:0] mem_wline,
    output logic [CNT_W-1:0]  i_miss_cnt,
    output logic [CNT_W-1:0]  d_miss_cnt,
    output logic [CNT_W-1:0]  evict_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVICT = 2'd1,
        S_DFILL = 2'd2,
        S_IFILL = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_i_miss_cnt;
    logic [CNT_W-1:0] r_d_miss_cnt;
    logic [CNT_W-1:0] r_evict_cnt;

    logic [OFF_W-1:0] w_i_off;
    logic [OFF_W-1:0] w_d_off;
    logic [LA_W-1:0]  w_i_la;
    logic [LA_W-1:0]  w_d_la;
    logic             w_dreq;
    logic             w_dmiss;
    logic             w_imiss;
    logic             w_take_d;
    logic             w_in_idle;
    logic             w_go_ifill;
    logic             w_go_evict;
    logic             w_go_dfill;

    function automatic logic [WORD_W-1:0] f_word(
        input logic [LINE_W-1:0] line,
        input logic [OFF_W-1:0]  off
    );
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < WPL; k++) begin
            if (off == OFF_W'(k)) w = line[k*WORD_W +: WORD_W];
        end
        return w;
    endfunction

    function automatic logic [LINE_W-1:0] f_merge(
        input logic [LINE_W-1:0] line,
        input logic [OFF_W-1:0]  off,
        input logic [WORD_W-1:0] word
    );
        logic [LINE_W-1:0] l;
        l = line;
        for (int k = 0; k < WPL; k++) begin
            if (off == OFF_W'(k)) l[k*WORD_W +: WORD_W] = word;
        end
        return l;
    endfunction

    assign w_i_off = i_addr[OFF_W-1:0];
    assign w_d_off = d_addr[OFF_W-1:0];
    assign w_i_la  = i_addr[ADDR_W-1:OFF_W];
    assign w_d_la  = d_addr[ADDR_W-1:OFF_W];

    // a store wins over a load when both strobes are high
    assign w_dreq   = d_rd | d_wr;
    assign w_dmiss  = w_dreq & ~d_hit;
    assign w_imiss  = ~i_hit;
    assign w_take_d = w_dmiss & (~w_imiss | (PRIO_D != 0));

    assign w_in_idle  = (r_state == S_IDLE);
    assign w_go_ifill = w_in_idle && (w_next == S_IFILL);
    assign w_go_evict = w_in_idle && (w_next == S_EVICT);
    assign w_go_dfill = w_in_idle && (w_next == S_DFILL);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // saturating miss/eviction statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_miss_cnt <= '0;
            r_d_miss_cnt <= '0;
            r_evict_cnt  <= '0;
        end else begin
            if (w_go_ifill && (r_i_miss_cnt != '1))
                r_i_miss_cnt <= r_i_miss_cnt + CNT_W'(1);
            if ((w_go_evict || w_go_dfill) && (r_d_miss_cnt != '1))
                r_d_miss_cnt <= r_d_miss_cnt + CNT_W'(1);
            if (w_go_evict && (r_evict_cnt != '1))
                r_evict_cnt <= r_evict_cnt + CNT_W'(1);
        end
    end

    assign i_miss_cnt = r_i_miss_cnt;
    assign d_miss_cnt = r_d_miss_cnt;
    assign evict_cnt  = r_evict_cnt;

    // next-state and output decode; strobes are squashed while in reset
    always_comb begin
        w_next        = r_state;
        instr         = '0;
        i_rdy         = 1'b0;
        d_rdata       = '0;
        d_rdy         = 1'b0;
        icache_we     = 1'b0;
        dcache_we     = 1'b0;
        dcache_wdirty = 1'b0;
        dcache_wline  = '0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        mem_la        = '0;
        mem_wline     = '0;
        case (r_state)
            S_IDLE: begin
                i_rdy = i_hit;
                instr = f_word(i_line, w_i_off);
                if (w_dreq && d_hit) begin
                    d_rdy   = 1'b1;
                    d_rdata = f_word(d_line, w_d_off);
                    if (d_wr) begin
                        dcache_we     = 1'b1;
                        dcache_wdirty = 1'b1;
                        dcache_wline  = f_merge(d_line, w_d_off, d_wdata);
                    end
                end
                if (w_take_d)
                    w_next = d_dirty ? S_EVICT : S_DFILL;
                else if (w_imiss)
                    w_next = S_IFILL;
            end
            S_EVICT: begin
                mem_we    = 1'b1;
                mem_la    = d_victim_la;
                mem_wline = d_line;
                if (mem_rdy) w_next = S_DFILL;
            end
            S_DFILL: begin
                mem_re = 1'b1;
                mem_la = w_d_la;
                if (mem_rdy) begin
                    dcache_we     = 1'b1;
                    dcache_wdirty = d_wr;
                    dcache_wline  = d_wr ?
                        f_merge(mem_rdata, w_d_off, d_wdata) : mem_rdata;
                    d_rdy         = 1'b1;
                    d_rdata       = f_word(mem_rdata, w_d_off);
                    w_next        = S_IDLE;
                end
            end
            S_IFILL: begin
                mem_re = 1'b1;
                mem_la = w_i_la;
                if (mem_rdy) begin
                    icache_we = 1'b1;
                    i_rdy     = 1'b1;
                    instr     = f_word(mem_rdata, w_i_off);
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (!rst_n) begin
            i_rdy     = 1'b0;
            d_rdy     = 1'b0;
            icache_we = 1'b0;
            dcache_we = 1'b0;
            mem_re    = 1'b0;
            mem_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb_cache_ctrl_wb: randomized transaction-level checks of cache_ctrl_wb.
// The bench plays both caches and the memory; u0 is default, u1 is PRIO_D=0/CNT_W=2.
module tb_cache_ctrl_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_hit, i_hit_b, d_hit, d_hit_b;
    logic        d_rd, d_wr, d_dirty, mem_rdy, mem_rdy_b;
    logic [63:0] i_line, d_line, mem_rdata;
    logic [13:0] d_victim_la;

    logic [15:0] instr, d_rdata;
    logic        i_rdy, d_rdy, icache_we, dcache_we, dcache_wdirty;
    logic [63:0] dcache_wline, mem_wline;
    logic        mem_re, mem_we;
    logic [13:0] mem_la;
    logic [15:0] i_miss_cnt, d_miss_cnt, evict_cnt;

    logic [15:0] instr_b, d_rdata_b;
    logic        i_rdy_b, d_rdy_b, icache_we_b, dcache_we_b, dcache_wdirty_b;
    logic [63:0] dcache_wline_b, mem_wline_b;
    logic        mem_re_b, mem_we_b;
    logic [13:0] mem_la_b;
    logic [1:0]  i_miss_cnt_b, d_miss_cnt_b, evict_cnt_b;

    int n_cmp = 0;
    int n_err = 0;
    int e_im = 0, e_dm = 0, e_ev = 0;
    int e_im_b = 0, e_dm_b = 0;

    always #5 clk = ~clk;

    cache_ctrl_wb u0 (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_hit(i_hit), .i_line(i_line),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
        .d_hit(d_hit), .d_dirty(d_dirty), .d_line(d_line),
        .d_victim_la(d_victim_la),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .instr(instr), .i_rdy(i_rdy), .d_rdata(d_rdata), .d_rdy(d_rdy),
        .icache_we(icache_we), .dcache_we(dcache_we),
        .dcache_wdirty(dcache_wdirty), .dcache_wline(dcache_wline),
        .mem_re(mem_re), .mem_we(mem_we), .mem_la(mem_la),
        .mem_wline(mem_wline),
        .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt),
        .evict_cnt(evict_cnt)
    );

    cache_ctrl_wb #(.PRIO_D(0), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_hit(i_hit_b), .i_line(i_line),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
        .d_hit(d_hit_b), .d_dirty(d_dirty), .d_line(d_line),
        .d_victim_la(d_victim_la),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy_b),
        .instr(instr_b), .i_rdy(i_rdy_b), .d_rdata(d_rdata_b),
        .d_rdy(d_rdy_b),
        .icache_we(icache_we_b), .dcache_we(dcache_we_b),
        .dcache_wdirty(dcache_wdirty_b), .dcache_wline(dcache_wline_b),
        .mem_re(mem_re_b), .mem_we(mem_we_b), .mem_la(mem_la_b),
        .mem_wline(mem_wline_b),
        .i_miss_cnt(i_miss_cnt_b), .d_miss_cnt(d_miss_cnt_b),
        .evict_cnt(evict_cnt_b)
    );

    // reference helpers: word n of a line is bits [16n+15:16n]
    function automatic logic [15:0] wsel(input logic [63:0] l, input int o);
        logic [63:0] t;
        t = (l >> (16 * o)) & 64'hFFFF;
        return t[15:0];
    endfunction

    function automatic logic [63:0] wput(input logic [63:0] l, input int o,
                                         input logic [15:0] w);
        return (l & ~(64'hFFFF << (16 * o))) | ({48'd0, w} << (16 * o));
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        i_hit = 1'b1; i_hit_b = 1'b1; d_hit = 1'b1; d_hit_b = 1'b1;
        d_rd = 1'b0; d_wr = 1'b0; d_dirty = 1'b0;
        mem_rdy = 1'b0; mem_rdy_b = 1'b0;
        i_addr = 16'($urandom); d_addr = 16'($urandom);
        d_wdata = 16'($urandom); d_victim_la = 14'($urandom);
        i_line = r64(); d_line = r64(); mem_rdata = r64();
    endtask

    task automatic test_reset();
        idle_inputs();
        d_rd = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({i_rdy, d_rdy, icache_we, dcache_we, mem_re, mem_we,
             i_rdy_b, d_rdy_b} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 0",
                {i_rdy, d_rdy, icache_we, dcache_we, mem_re, mem_we,
                 i_rdy_b, d_rdy_b});
        end
        n_cmp++;
        if ({i_miss_cnt, d_miss_cnt, evict_cnt} !== 48'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %h want 0",
                {i_miss_cnt, d_miss_cnt, evict_cnt});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({i_rdy, d_rdy, mem_re, mem_we} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_exit: got %b want 1100",
                {i_rdy, d_rdy, mem_re, mem_we});
        end
    endtask

    task automatic test_hit_path();
        int off;
        logic st;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            idle_inputs();
            mem_rdy = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       begin d_rd = 1'b1; d_wr = 1'b0; end
                1:       begin d_rd = 1'b0; d_wr = 1'b1; end
                default: begin d_rd = 1'b1; d_wr = 1'b1; end
            endcase
            if (n == 0) begin
                d_rd = 1'b1; d_wr = 1'b0;
                d_addr[1:0] = 2'd2;
                d_line[47:32] = 16'hBEEF;
            end
            off = int'(d_addr[1:0]);
            st = d_wr;
            #1;
            n_cmp++;
            if ({i_rdy, instr} !== {1'b1, wsel(i_line, int'(i_addr[1:0]))}) begin
                n_err++;
                $display("FAIL hit_instr: got %b/%h want 1/%h", i_rdy, instr,
                    wsel(i_line, int'(i_addr[1:0])));
            end
            n_cmp++;
            if ({d_rdy, d_rdata} !== {1'b1, wsel(d_line, off)}) begin
                n_err++;
                $display("FAIL hit_data: got %b/%h want 1/%h", d_rdy, d_rdata,
                    wsel(d_line, off));
            end
            n_cmp++;
            if ({dcache_we, dcache_wdirty, icache_we, mem_re, mem_we}
                !== {st, st, 3'b000}) begin
                n_err++;
                $display("FAIL hit_strobes: got %b want %b",
                    {dcache_we, dcache_wdirty, icache_we, mem_re, mem_we},
                    {st, st, 3'b000});
            end
            if (st) begin
                n_cmp++;
                if (dcache_wline !== wput(d_line, off, d_wdata)) begin
                    n_err++;
                    $display("FAIL hit_wline: got %h want %h", dcache_wline,
                        wput(d_line, off, d_wdata));
                end
            end
        end
    endtask

    task automatic dmiss(input logic st, input logic dirty,
                         input int l1, input int l2, input logic fixed);
        int off;
        logic last;
        @(negedge clk);
        idle_inputs();
        d_rd = st ? 1'($urandom_range(0, 1)) : 1'b1;
        d_wr = st;
        d_hit = 1'b0;
        d_dirty = dirty;
        mem_rdy = 1'($urandom_range(0, 1));
        if (fixed) begin
            d_victim_la = 14'h123;
            d_wdata = 16'h5A5A;
        end
        off = int'(d_addr[1:0]);
        #1;
        n_cmp++;
        if ({i_rdy, d_rdy, dcache_we, mem_re, mem_we} !== 5'b10000) begin
            n_err++;
            $display("FAIL dmiss_req: got %b want 10000",
                {i_rdy, d_rdy, dcache_we, mem_re, mem_we});
        end
        if (dirty) begin
            for (int c = 0; c <= l1; c++) begin
                @(negedge clk);
                mem_rdy = (c == l1);
                #1;
                n_cmp++;
                if ({mem_we, mem_re, i_rdy, d_rdy, dcache_we, mem_la, mem_wline}
                    !== {5'b10000, d_victim_la, d_line}) begin
                    n_err++;
                    $display("FAIL evict: got %b/%h/%h want 10000/%h/%h",
                        {mem_we, mem_re, i_rdy, d_rdy, dcache_we}, mem_la,
                        mem_wline, d_victim_la, d_line);
                end
            end
        end
        for (int c = 0; c <= l2; c++) begin
            @(negedge clk);
            mem_rdy = (c == l2);
            last = (c == l2);
            #1;
            n_cmp++;
            if ({mem_re, mem_we, i_rdy, icache_we, mem_la,
                 d_rdy, dcache_we, dcache_wdirty}
                !== {4'b1000, d_addr[15:2], last, last, last & st}) begin
                n_err++;
                $display("FAIL dfill: got %b/%h/%b want 1000/%h/%b",
                    {mem_re, mem_we, i_rdy, icache_we}, mem_la,
                    {d_rdy, dcache_we, dcache_wdirty}, d_addr[15:2],
                    {last, last, last & st});
            end
            if (last) begin
                n_cmp++;
                if ({d_rdata, dcache_wline} !== {wsel(mem_rdata, off),
                    st ? wput(mem_rdata, off, d_wdata) : mem_rdata}) begin
                    n_err++;
                    $display("FAIL dfill_data: got %h/%h want %h/%h",
                        d_rdata, dcache_wline, wsel(mem_rdata, off),
                        st ? wput(mem_rdata, off, d_wdata) : mem_rdata);
                end
            end
        end
        e_dm++;
        if (dirty) e_ev++;
        @(negedge clk);
        d_hit = 1'b1;
        mem_rdy = 1'b0;
        #1;
        n_cmp++;
        if ({mem_re, mem_we, d_rdy, i_miss_cnt, d_miss_cnt, evict_cnt}
            !== {3'b001, 16'(sat(e_im, 65535)), 16'(sat(e_dm, 65535)),
                 16'(sat(e_ev, 65535))}) begin
            n_err++;
            $display("FAIL dmiss_post: got %b/%0d/%0d/%0d want 001/%0d/%0d/%0d",
                {mem_re, mem_we, d_rdy}, i_miss_cnt, d_miss_cnt, evict_cnt,
                e_im, e_dm, e_ev);
        end
    endtask

    task automatic imiss(input int l);
        logic last;
        @(negedge clk);
        idle_inputs();
        i_hit = 1'b0;
        d_rd = 1'($urandom_range(0, 1));
        #1;
        n_cmp++;
        if ({i_rdy, d_rdy, mem_re, mem_we} !== {1'b0, d_rd, 2'b00}) begin
            n_err++;
            $display("FAIL imiss_req: got %b want %b",
                {i_rdy, d_rdy, mem_re, mem_we}, {1'b0, d_rd, 2'b00});
        end
        for (int c = 0; c <= l; c++) begin
            @(negedge clk);
            mem_rdy = (c == l);
            last = (c == l);
            #1;
            n_cmp++;
            if ({mem_re, mem_we, d_rdy, dcache_we, mem_la, i_rdy, icache_we}
                !== {4'b1000, i_addr[15:2], last, last}) begin
                n_err++;
                $display("FAIL ifill: got %b/%h/%b want 1000/%h/%b",
                    {mem_re, mem_we, d_rdy, dcache_we}, mem_la,
                    {i_rdy, icache_we}, i_addr[15:2], {last, last});
            end
            if (last) begin
                n_cmp++;
                if (instr !== wsel(mem_rdata, int'(i_addr[1:0]))) begin
                    n_err++;
                    $display("FAIL ifill_instr: got %h want %h", instr,
                        wsel(mem_rdata, int'(i_addr[1:0])));
                end
            end
        end
        e_im++;
        @(negedge clk);
        i_hit = 1'b1;
        mem_rdy = 1'b0;
        #1;
        n_cmp++;
        if ({mem_re, i_rdy, i_miss_cnt} !== {2'b01, 16'(sat(e_im, 65535))}) begin
            n_err++;
            $display("FAIL imiss_post: got %b/%0d want 01/%0d",
                {mem_re, i_rdy}, i_miss_cnt, e_im);
        end
    endtask

    task automatic test_dmiss();
        dmiss(1'b1, 1'b1, 3, 3, 1'b1);
        for (int n = 0; n < 10; n++)
            dmiss(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    endtask

    task automatic test_imiss();
        for (int n = 0; n < 6; n++) imiss($urandom_range(0, 3));
    endtask

    task automatic test_zero_wait();
        dmiss(1'b0, 1'b0, 0, 0, 1'b0);
        dmiss(1'b1, 1'b1, 0, 0, 1'b0);
        imiss(0);
    endtask

    task automatic test_prio_d();
        int l;
        l = $urandom_range(0, 2);
        @(negedge clk);
        idle_inputs();
        i_hit = 1'b0; d_rd = 1'b1; d_hit = 1'b0;
        #1;
        n_cmp++;
        if ({i_rdy, d_rdy, mem_re, mem_we} !== 4'b0000) begin
            n_err++;
            $display("FAIL prio_d_req: got %b want 0000",
                {i_rdy, d_rdy, mem_re, mem_we});
        end
        for (int c = 0; c <= l; c++) begin
            @(negedge clk);
            mem_rdy = (c == l);
            #1;
            n_cmp++;
            if ({mem_re, mem_la, d_rdy, i_rdy}
                !== {1'b1, d_addr[15:2], c == l, 1'b0}) begin
                n_err++;
                $display("FAIL prio_d_first: got %b/%h/%b want 1/%h/%b",
                    mem_re, mem_la, {d_rdy, i_rdy}, d_addr[15:2],
                    {c == l, 1'b0});
            end
        end
        @(negedge clk);
        d_hit = 1'b1; mem_rdy = 1'b0; mem_rdata = r64();
        #1;
        n_cmp++;
        if ({d_rdy, i_rdy, mem_re} !== 3'b100) begin
            n_err++;
            $display("FAIL prio_d_gap: got %b want 100",
                {d_rdy, i_rdy, mem_re});
        end
        for (int c = 0; c <= l; c++) begin
            @(negedge clk);
            mem_rdy = (c == l);
            #1;
            n_cmp++;
            if ({mem_re, mem_la, i_rdy, d_rdy}
                !== {1'b1, i_addr[15:2], c == l, 1'b0}) begin
                n_err++;
                $display("FAIL prio_d_second: got %b/%h/%b want 1/%h/%b",
                    mem_re, mem_la, {i_rdy, d_rdy}, i_addr[15:2],
                    {c == l, 1'b0});
            end
        end
        e_im++; e_dm++;
        @(negedge clk);
        i_hit = 1'b1; mem_rdy = 1'b0;
        #1;
        n_cmp++;
        if ({i_miss_cnt, d_miss_cnt} !== {16'(e_im), 16'(e_dm)}) begin
            n_err++;
            $display("FAIL prio_d_cnt: got %0d/%0d want %0d/%0d",
                i_miss_cnt, d_miss_cnt, e_im, e_dm);
        end
    endtask

    task automatic test_prio_i();
        int l;
        l = $urandom_range(0, 2);
        @(negedge clk);
        idle_inputs();
        i_hit_b = 1'b0; d_rd = 1'b1; d_hit_b = 1'b0;
        #1;
        for (int c = 0; c <= l; c++) begin
            @(negedge clk);
            mem_rdy_b = (c == l);
            #1;
            n_cmp++;
            if ({mem_re_b, mem_la_b, i_rdy_b, d_rdy_b}
                !== {1'b1, i_addr[15:2], c == l, 1'b0}) begin
                n_err++;
                $display("FAIL prio_i_first: got %b/%h/%b want 1/%h/%b",
                    mem_re_b, mem_la_b, {i_rdy_b, d_rdy_b}, i_addr[15:2],
                    {c == l, 1'b0});
            end
        end
        @(negedge clk);
        i_hit_b = 1'b1; mem_rdy_b = 1'b0;
        #1;
        n_cmp++;
        if ({i_rdy_b, d_rdy_b, mem_re_b} !== 3'b100) begin
            n_err++;
            $display("FAIL prio_i_gap: got %b want 100",
                {i_rdy_b, d_rdy_b, mem_re_b});
        end
        for (int c = 0; c <= l; c++) begin
            @(negedge clk);
            mem_rdy_b = (c == l);
            #1;
            n_cmp++;
            if ({mem_re_b, mem_la_b, d_rdy_b, i_rdy_b}
                !== {1'b1, d_addr[15:2], c == l, 1'b0}) begin
                n_err++;
                $display("FAIL prio_i_second: got %b/%h/%b want 1/%h/%b",
                    mem_re_b, mem_la_b, {d_rdy_b, i_rdy_b}, d_addr[15:2],
                    {c == l, 1'b0});
            end
        end
        e_im_b++; e_dm_b++;
        @(negedge clk);
        d_hit_b = 1'b1; mem_rdy_b = 1'b0;
        #1;
        n_cmp++;
        if ({i_miss_cnt_b, d_miss_cnt_b}
            !== {2'(sat(e_im_b, 3)), 2'(sat(e_dm_b, 3))}) begin
            n_err++;
            $display("FAIL prio_i_cnt: got %0d/%0d want %0d/%0d",
                i_miss_cnt_b, d_miss_cnt_b, e_im_b, e_dm_b);
        end
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        idle_inputs();
        d_rd = 1'b1; d_hit = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (mem_re !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_setup: got mem_re=%b want 1", mem_re);
        end
        @(negedge clk);
        rst_n = 1'b0;
        mem_rdy = 1'b1;
        e_im = 0; e_dm = 0; e_ev = 0; e_im_b = 0; e_dm_b = 0;
        #1;
        n_cmp++;
        if ({dcache_we, d_rdy, mem_re, i_rdy, icache_we, i_miss_cnt,
             d_miss_cnt, evict_cnt, i_miss_cnt_b, d_miss_cnt_b} !== 57'd0) begin
            n_err++;
            $display("FAIL rst_mid_async: got %b/%0d/%0d/%0d/%0d/%0d want 0",
                {dcache_we, d_rdy, mem_re, i_rdy, icache_we}, i_miss_cnt,
                d_miss_cnt, evict_cnt, i_miss_cnt_b, d_miss_cnt_b);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({dcache_we, d_rdy} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_hold: got %b want 00", {dcache_we, d_rdy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({mem_re, mem_we, d_rdy, i_rdy} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_mid_exit: got %b want 0001",
                {mem_re, mem_we, d_rdy, i_rdy});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({mem_re, d_rdy, dcache_we} !== 3'b111) begin
            n_err++;
            $display("FAIL rst_mid_refill: got %b want 111",
                {mem_re, d_rdy, dcache_we});
        end
        e_dm++;
        @(negedge clk);
        d_hit = 1'b1; mem_rdy = 1'b0;
        #1;
        n_cmp++;
        if (d_miss_cnt !== 16'(e_dm)) begin
            n_err++;
            $display("FAIL rst_mid_cnt: got %0d want %0d", d_miss_cnt, e_dm);
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            idle_inputs();
            i_hit_b = 1'b0;
            #1;
            n_cmp++;
            if ({i_rdy_b, mem_re_b} !== 2'b00) begin
                n_err++;
                $display("FAIL sat_req: got %b want 00", {i_rdy_b, mem_re_b});
            end
            @(negedge clk);
            mem_rdy_b = 1'b1;
            #1;
            n_cmp++;
            if ({mem_re_b, i_rdy_b, icache_we_b} !== 3'b111) begin
                n_err++;
                $display("FAIL sat_fill: got %b want 111",
                    {mem_re_b, i_rdy_b, icache_we_b});
            end
            e_im_b++;
            @(negedge clk);
            i_hit_b = 1'b1; mem_rdy_b = 1'b0;
            #1;
            n_cmp++;
            if ({i_miss_cnt_b, d_miss_cnt_b}
                !== {2'(sat(e_im_b, 3)), 2'(sat(e_dm_b, 3))}) begin
                n_err++;
                $display("FAIL sat_cnt: got %0d/%0d want %0d/%0d",
                    i_miss_cnt_b, d_miss_cnt_b, sat(e_im_b, 3),
                    sat(e_dm_b, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit_path();
        test_dmiss();
        test_imiss();
        test_zero_wait();
        test_prio_d();
        test_prio_i();
        test_reset_mid_fill();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_wb.md
CACHE_CTRL_WB -- requirements
Module: cache_ctrl_wb

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- WORD_W, 16, word width.
- WPL, 4, words per line; power of 2, at least 2.
- ADDR_W, 16, word address width.
- CNT_W, 16, statistics counter width.
- PRIO_D, 1, 1 = data miss wins a simultaneous miss, 0 = instruction miss wins.

REQ-002 SHALL derive LINE_W=WORD_W*WPL, OFF_W=log2(WPL), LA_W=ADDR_W-OFF_W.

REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- i_addr, in, ADDR_W, fetch address.
- i_hit, in, 1, icache hit.
- i_line, in, LINE_W, icache line.
- d_addr, in, ADDR_W, data address.
- d_rd, in, 1, load request.
- d_wr, in, 1, store request.
- d_wdata, in, WORD_W, store data.
- d_hit, in, 1, dcache hit.
- d_dirty, in, 1, victim dirty.
- d_line, in, LINE_W, dcache line (victim on miss).
- d_victim_la, in, LA_W, victim line address.
- mem_rdata, in, LINE_W, memory line.
- mem_rdy, in, 1, memory done.
- instr, out, WORD_W, fetched word.
- i_rdy, out, 1, instr valid.
- d_rdata, out, WORD_W, load word.
- d_rdy, out, 1, data op complete.
- icache_we, out, 1, icache fill strobe.
- dcache_we, out, 1, dcache write strobe.
- dcache_wdirty, out, 1, dirty bit written.
- dcache_wline, out, LINE_W, dcache write line.
- mem_re, out, 1, memory read.
- mem_we, out, 1, memory write.
- mem_la, out, LA_W, memory line address.
- mem_wline, out, LINE_W, memory write data.
- i_miss_cnt, out, CNT_W, statistics counter.
- d_miss_cnt, out, CNT_W, statistics counter.
- evict_cnt, out, CNT_W, statistics counter.

Function
REQ-004 SHALL implement the states IDLE, EVICT, DFILL and IFILL.
REQ-005 SHALL select words as line[(off+1)*WORD_W-1 : off*WORD_W], where off is the address bits [OFF_W-1:0].
REQ-006 SHALL define a data request as d_rd|d_wr; d_rd and d_wr both high SHALL be treated as a store.
REQ-007 In IDLE, SHALL assert i_rdy=i_hit and instr=word(i_line) combinationally.
REQ-008 In IDLE with a data request and d_hit: d_rdy=1, d_rdata=word(d_line) that cycle.
REQ-009 In IDLE with a store hit: dcache_we=1, dcache_wdirty=1, dcache_wline=d_line with the addressed word replaced by d_wdata, same cycle.
REQ-010 In IDLE, when only a data miss is pending, SHALL go to EVICT if d_dirty, else to DFILL.
REQ-011 In IDLE, when only an instruction miss is pending (~i_hit), SHALL go to IFILL.
REQ-012 When both misses are pending, SHALL service the PRIO_D-selected miss first; the loser SHALL be serviced on a later IDLE pass.
REQ-013 A data hit SHALL complete in IDLE even when an instruction miss is pending in the same cycle.
REQ-014 In EVICT: mem_we=1, mem_la=d_victim_la, mem_wline=d_line, held until mem_rdy; then go to DFILL.
REQ-015 In DFILL: mem_re=1, mem_la=d_addr[ADDR_W-1:OFF_W], held until mem_rdy.
REQ-016 On the DFILL mem_rdy cycle:
- dcache_we=1.
- dcache_wline=mem_rdata, with d_wdata merged into the addressed word if the request is a store.
- dcache_wdirty=d_wr.
- d_rdy=1, d_rdata=word(mem_rdata).
- next state IDLE.
REQ-017 In IFILL: mem_re=1, mem_la=i_addr[ADDR_W-1:OFF_W], held until mem_rdy.
REQ-018 On the IFILL mem_rdy cycle: icache_we=1, i_rdy=1, instr=word(mem_rdata); next state IDLE.
REQ-019 In EVICT, DFILL and IFILL, i_rdy and d_rdy SHALL be 0 except as stated in REQ-016 and REQ-018.
REQ-020 mem_re and mem_we SHALL never be high together, and both SHALL be 0 in IDLE.
REQ-021 Requesters SHALL hold their address and data stable until the matching rdy; the controller SHALL NOT register them.
REQ-022 mem_rdy SHALL be ignored in IDLE; a zero-wait mem_rdy (high on the first cycle of a state) SHALL complete that state in one cycle.
REQ-023 i_miss_cnt SHALL increment on each IDLE->IFILL transition and saturate at all-ones.
REQ-024 d_miss_cnt SHALL increment on each IDLE->EVICT or IDLE->DFILL transition and saturate at all-ones.
REQ-025 evict_cnt SHALL increment on each IDLE->EVICT transition and saturate at all-ones.
REQ-026 Outputs not driven by REQ-007 to REQ-018 SHALL be 0.
REQ-027 An illegal state SHALL return to IDLE on the next clock.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE and all counters to 0, independent of clk.
REQ-029 While rst_n is low, all control outputs (rdy, we, re) SHALL be 0.
REQ-030 Reset asserted mid-EVICT, mid-DFILL or mid-IFILL SHALL abandon the transaction: no cache write, no rdy, counters cleared.
REQ-031 After rst_n rises, the first transition SHALL occur on the next clk rising edge.

Verification
REQ-032 Hit path (defaults): i_hit=1, d_rd=1, d_hit=1, d_addr[1:0]=2, d_line word2=0xBEEF -> d_rdy=1, d_rdata=0xBEEF, i_rdy=1 same cycle; state stays IDLE.
REQ-033 Dirty store miss: d_wr=1, d_hit=0, d_dirty=1, d_victim_la=0x123, d_wdata=0x5A5A, mem_rdy 3 cycles after each request ->
- EVICT: mem_we=1 with mem_la=0x123.
- then DFILL: mem_re=1.
- completion cycle: dcache_wline word = 0x5A5A, dcache_wdirty=1, d_rdy=1.
- counters: d_miss_cnt=1, evict_cnt=1.
REQ-034 Simultaneous misses, PRIO_D=1: DFILL completes first, then IFILL; i_miss_cnt=1, d_miss_cnt=1. Repeat with PRIO_D=0 -> IFILL first.
REQ-035 Zero-wait memory: mem_rdy tied 1, clean load miss -> d_rdy exactly one cycle after the request is presented.
REQ-036 rst_n pulsed low mid-DFILL -> state IDLE immediately, no dcache_we pulse, all counters 0.
REQ-037 CNT_W=2, five instruction misses -> i_miss_cnt saturates at 3.
